// File: rtl/mcp300x_scanner.sv
// Round-robin scan engine for MCP3004/3008 SPI A/D converters with a per-channel result bank.
// Define MCP300X_SCAN_AVG_EN to store the average of every four conversions per channel.
module mcp300x_scanner #(
  parameter int unsigned DIVIDER     = 12,
  parameter int unsigned N_CHN       = 8,
  parameter int unsigned CS_HI_TICKS = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             single_i,
  input  logic [N_CHN-1:0] chn_mask_i,
  input  logic [2:0]       rd_chn_i,
  output logic [9:0]       rd_data_o,
  output logic [N_CHN-1:0] valid_o,
  output logic             eoc_o,
  output logic [2:0]       eoc_chn_o,
  output logic             busy_o,
  output logic             ad_ncs_o,
  output logic             ad_clk_o,
  output logic             ad_din_o,
  input  logic             ad_dout_i
);

  localparam int unsigned DivW     = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int unsigned HiW      = (CS_HI_TICKS > 1) ? $clog2(CS_HI_TICKS + 1) : 1;
  localparam logic [5:0]  LastHalf = 6'd33;

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StDone, StCsHi} state_e;

  // ---------------------------------------------------------------------------
  // SPI half-period tick
  // ---------------------------------------------------------------------------
  logic [DivW-1:0] div_q;
  logic            tick;

  assign tick = (div_q == DivW'(DIVIDER - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel selection
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] next_chn(input logic [2:0] cur, input logic [N_CHN-1:0] mask);
    logic       found;
    logic [2:0] res;
    found = 1'b0;
    res   = cur;
    for (int i = 0; i < int'(N_CHN); i++) begin
      if (!found && mask[i] && (i > int'(cur))) begin
        res   = 3'(i);
        found = 1'b1;
      end
    end
    // Nothing above the current channel: wrap to the lowest enabled one.
    for (int i = 0; i < int'(N_CHN); i++) begin
      if (!found && mask[i]) begin
        res   = 3'(i);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  state_e          state_q;
  logic [5:0]      half_q;
  logic [HiW-1:0]  hi_q;
  logic [2:0]      chn_q;
  logic [9:0]      sr_q;
  logic            ncs_q;
  logic            sclk_q;
  logic            din_q;
  logic            busy_q;
  logic [2:0]      chn_nxt;
  logic            start_ok;
  logic [4:0]      rise_k;
  logic            din_nxt;

  assign chn_nxt  = next_chn(chn_q, chn_mask_i);
  assign start_ok = run_i && (|chn_mask_i);
  assign rise_k   = half_q[5:1];

  // Command bit presented on fall k, sampled by the A/D on rise k+1.
  always_comb begin
    din_nxt = 1'b0;
    case (rise_k)
      5'd0:    din_nxt = single_i;
      5'd1:    din_nxt = chn_q[2];
      5'd2:    din_nxt = chn_q[1];
      5'd3:    din_nxt = chn_q[0];
      default: din_nxt = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer; half_q counts SCLK half periods (even = rise, odd = fall)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      half_q  <= '0;
      hi_q    <= '0;
      chn_q   <= 3'(N_CHN - 1);
      sr_q    <= '0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            chn_q   <= chn_nxt;
            ncs_q   <= 1'b0;
            busy_q  <= 1'b1;
            din_q   <= 1'b1;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          sclk_q  <= 1'b1;
          half_q  <= 6'd1;
          state_q <= StShift;
        end
        StShift: begin
          half_q <= half_q + 6'd1;
          if (half_q[0]) begin
            sclk_q <= 1'b0;
            din_q  <= din_nxt;
            if (half_q == LastHalf) begin
              state_q <= StDone;
            end
          end else begin
            sclk_q <= 1'b1;
            if (rise_k >= 5'd7) begin
              sr_q <= {sr_q[8:0], ad_dout_i};
            end
          end
        end
        StDone: begin
          ncs_q   <= 1'b1;
          busy_q  <= 1'b0;
          hi_q    <= '0;
          state_q <= StCsHi;
        end
        StCsHi: begin
          if (hi_q == HiW'(CS_HI_TICKS - 1)) begin
            if (start_ok) begin
              chn_q   <= chn_nxt;
              ncs_q   <= 1'b0;
              busy_q  <= 1'b1;
              din_q   <= 1'b1;
              state_q <= StSetup;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            hi_q <= hi_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ad_ncs_o = ncs_q;
  assign ad_clk_o = sclk_q;
  assign ad_din_o = din_q;
  assign busy_o   = busy_q;

  // ---------------------------------------------------------------------------
  // Result bank
  // ---------------------------------------------------------------------------
  logic             wr_en;
  logic [9:0]       res_q [N_CHN];
  logic [N_CHN-1:0] valid_q;
  logic             eoc_q;
  logic [2:0]       eoc_chn_q;
  logic [9:0]       rd_data_q;

  assign wr_en = tick && (state_q == StDone);

`ifdef MCP300X_SCAN_AVG_EN
  logic [11:0] acc_q [N_CHN];
  logic [1:0]  cnt_q [N_CHN];
  logic [11:0] acc_sum;

  assign acc_sum = acc_q[chn_q] + {2'b00, sr_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(N_CHN); i++) begin
        res_q[i] <= '0;
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      valid_q   <= '0;
      eoc_q     <= 1'b0;
      eoc_chn_q <= '0;
    end else begin
      eoc_q <= 1'b0;
      if (wr_en) begin
        if (cnt_q[chn_q] == 2'd3) begin
          res_q[chn_q]   <= acc_sum[11:2];
          acc_q[chn_q]   <= '0;
          cnt_q[chn_q]   <= '0;
          valid_q[chn_q] <= 1'b1;
          eoc_q          <= 1'b1;
          eoc_chn_q      <= chn_q;
        end else begin
          acc_q[chn_q] <= acc_sum;
          cnt_q[chn_q] <= cnt_q[chn_q] + 2'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(N_CHN); i++) begin
        res_q[i] <= '0;
      end
      valid_q   <= '0;
      eoc_q     <= 1'b0;
      eoc_chn_q <= '0;
    end else begin
      eoc_q <= 1'b0;
      if (wr_en) begin
        res_q[chn_q]   <= sr_q;
        valid_q[chn_q] <= 1'b1;
        eoc_q          <= 1'b1;
        eoc_chn_q      <= chn_q;
      end
    end
  end
`endif

  // A read colliding with a write returns the pre-write value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (32'(rd_chn_i) < N_CHN) begin
      rd_data_q <= res_q[rd_chn_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;
  assign valid_o   = valid_q;
  assign eoc_o     = eoc_q;
  assign eoc_chn_o = eoc_chn_q;

endmodule

// File: tb/tb_mcp300x_scanner.sv
// Directed bench for mcp300x_scanner with a behavioural MCP3008 model on the SPI pins.
`timescale 1ns/1ps
module tb_mcp300x_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       single = 1'b1;
  logic [7:0] chn_mask = 8'h00;
  logic [2:0] rd_chn = 3'd0;
  logic [9:0] rd_data;
  logic [7:0] valid;
  logic       eoc;
  logic [2:0] eoc_chn;
  logic       busy;
  logic       ncs;
  logic       sclk;
  logic       din;
  logic       dout = 1'b0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mcp300x_scanner #(
    .DIVIDER    (12),
    .N_CHN      (8),
    .CS_HI_TICKS(2)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .run_i     (run),
    .single_i  (single),
    .chn_mask_i(chn_mask),
    .rd_chn_i  (rd_chn),
    .rd_data_o (rd_data),
    .valid_o   (valid),
    .eoc_o     (eoc),
    .eoc_chn_o (eoc_chn),
    .busy_o    (busy),
    .ad_ncs_o  (ncs),
    .ad_clk_o  (sclk),
    .ad_din_o  (din),
    .ad_dout_i (dout)
  );

  // A/D model: captures command bits on SCLK rises, drives B9..B0 after falls 6..15.
  logic [9:0] adc_val [8];
  logic [4:0] cmd = 5'd0;
  logic [4:0] frame_cmd [64];
  logic [2:0] eoc_log [64];
  int         rise_cnt = 0;
  int         last_rises = 0;
  int         nframes = 0;
  int         eoc_cnt = 0;
  logic       ncs_prev = 1'b1;
  logic       sclk_prev = 1'b0;

  always @(negedge clk) begin
    if (eoc) begin
      eoc_log[eoc_cnt % 64] <= eoc_chn;
      eoc_cnt <= eoc_cnt + 1;
    end
    if (ncs) begin
      if (!ncs_prev) last_rises <= rise_cnt;
      rise_cnt <= 0;
      dout     <= 1'b0;
    end else if (sclk && !sclk_prev) begin
      if (rise_cnt < 5) cmd[4 - rise_cnt] <= din;
      if (rise_cnt == 4) begin
        frame_cmd[nframes % 64] <= {cmd[4:1], din};
        nframes <= nframes + 1;
      end
      rise_cnt <= rise_cnt + 1;
    end else if (!sclk && sclk_prev) begin
      dout <= (rise_cnt >= 7 && rise_cnt <= 16) ? adc_val[cmd[2:0]][16 - rise_cnt] : 1'b0;
    end
    ncs_prev  <= ncs;
    sclk_prev <= sclk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_eoc_pulse(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (eoc) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    chn_mask = 8'h00;
    rd_chn = 3'd0;
    #1;
    checks++;
    if ({ncs, sclk, din, busy, eoc} !== 5'b10000)
      $display("FAIL reset_pins: got %b want 10000", {ncs, sclk, din, busy, eoc});
    else passed++;
    checks++;
    if ({eoc_chn, rd_data, valid} !== 21'd0)
      $display("FAIL reset_outputs: got %h want 0", {eoc_chn, rd_data, valid});
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if ({ncs, sclk, busy} !== 3'b100)
      $display("FAIL idle_no_run: got %b want 100", {ncs, sclk, busy});
    else passed++;
  endtask

  task automatic test_single_chn();
    bit ok;
    int f0;
    do_reset();
    adc_val[0] = 10'h2A5;
    single = 1'b1;
    chn_mask = 8'h01;
    rd_chn = 3'd0;
    f0 = nframes;
    run = 1'b1;
    wait_eoc_pulse(1500, ok);
    checks++;
    if (!ok) $display("FAIL ch0_eoc: got no eoc want eoc");
    else passed++;
    checks++;
    if (eoc_chn !== 3'd0) $display("FAIL ch0_eoc_chn: got %0d want 0", eoc_chn);
    else passed++;
    checks++;
    if (rd_data !== 10'h000) $display("FAIL ch0_rd_old: got %h want 000", rd_data);
    else passed++;
    @(negedge clk);
    checks++;
    if (eoc !== 1'b0) $display("FAIL eoc_width: got %b want 0", eoc);
    else passed++;
    checks++;
    if (rd_data !== 10'h2A5) $display("FAIL ch0_rd_new: got %h want 2a5", rd_data);
    else passed++;
    checks++;
    if (valid !== 8'h01) $display("FAIL ch0_valid: got %h want 01", valid);
    else passed++;
    checks++;
    if (frame_cmd[f0 % 64] !== 5'b11000)
      $display("FAIL ch0_din: got %b want 11000", frame_cmd[f0 % 64]);
    else passed++;
    checks++;
    if (last_rises !== 17) $display("FAIL sclk_rises: got %0d want 17", last_rises);
    else passed++;
    wait_eoc_pulse(1500, ok);
    checks++;
    if (!ok || eoc_chn !== 3'd0) $display("FAIL ch0_repeat: got ok=%b chn=%0d want 1/0", ok, eoc_chn);
    else passed++;
  endtask

  task automatic test_timing();
    int  lo, hi, cyc, r0, r1, c;
    bit  sclk_hi_bad, ok;
    logic sp;
    lo = 0; hi = 0; cyc = 0; r0 = -1; r1 = -1; sclk_hi_bad = 1'b0;
    c = 0;
    while (ncs !== 1'b1 && c < 1000) begin @(negedge clk); c++; end
    while (ncs !== 1'b0 && c < 2000) begin @(negedge clk); c++; end
    sp = sclk;
    while (ncs === 1'b0 && lo < 2000) begin
      if (sclk && !sp) begin
        if (r0 < 0) r0 = cyc;
        else if (r1 < 0) r1 = cyc;
      end
      sp = sclk;
      cyc++;
      lo++;
      @(negedge clk);
    end
    while (ncs === 1'b1 && hi < 2000) begin
      if (sclk !== 1'b0) sclk_hi_bad = 1'b1;
      hi++;
      @(negedge clk);
    end
    checks++;
    if (lo !== 420) $display("FAIL ncs_low_len: got %0d want 420", lo);
    else passed++;
    checks++;
    if (hi !== 24) $display("FAIL ncs_high_len: got %0d want 24", hi);
    else passed++;
    checks++;
    if (r1 - r0 !== 24) $display("FAIL sclk_period: got %0d want 24", r1 - r0);
    else passed++;
    checks++;
    if (sclk_hi_bad) $display("FAIL sclk_idle: got high want low while ncs high");
    else passed++;
    run = 1'b0;
    wait_eoc_pulse(1500, ok);
    repeat (60) @(negedge clk);
  endtask

  task automatic test_multi();
    logic [2:0] exp_order [4];
    bit ok;
    int f0;
    exp_order = '{3'd2, 3'd5, 3'd7, 3'd2};
    do_reset();
    adc_val[2] = 10'h155;
    adc_val[5] = 10'h0F0;
    adc_val[7] = 10'h3FF;
    single = 1'b0;
    chn_mask = 8'hA4;
    rd_chn = 3'd2;
    f0 = nframes;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_eoc_pulse(1500, ok);
      checks++;
      if (!ok || eoc_chn !== exp_order[i])
        $display("FAIL order_%0d: got ok=%b chn=%0d want %0d", i, ok, eoc_chn, exp_order[i]);
      else passed++;
      if (i == 0) begin
        checks++;
        if (rd_data !== 10'h000) $display("FAIL collide_old: got %h want 000", rd_data);
        else passed++;
        @(negedge clk);
        checks++;
        if (rd_data !== 10'h155) $display("FAIL collide_new: got %h want 155", rd_data);
        else passed++;
      end
      if (i == 2) begin
        checks++;
        if (valid !== 8'hA4) $display("FAIL valid_a4: got %h want a4", valid);
        else passed++;
      end
    end
    run = 1'b0;
    checks++;
    if ({frame_cmd[f0 % 64], frame_cmd[(f0 + 1) % 64], frame_cmd[(f0 + 2) % 64]}
        !== {5'b10010, 5'b10101, 5'b10111})
      $display("FAIL diff_din: got %b %b %b want 10010 10101 10111", frame_cmd[f0 % 64],
               frame_cmd[(f0 + 1) % 64], frame_cmd[(f0 + 2) % 64]);
    else passed++;
    rd_chn = 3'd5;
    repeat (2) @(negedge clk);
    checks++;
    if (rd_data !== 10'h0F0) $display("FAIL rd_ch5: got %h want 0f0", rd_data);
    else passed++;
    rd_chn = 3'd7;
    repeat (2) @(negedge clk);
    checks++;
    if (rd_data !== 10'h3FF) $display("FAIL rd_ch7: got %h want 3ff", rd_data);
    else passed++;
    rd_chn = 3'd3;
    repeat (2) @(negedge clk);
    checks++;
    if (rd_data !== 10'h000) $display("FAIL rd_ch3_empty: got %h want 000", rd_data);
    else passed++;
    repeat (60) @(negedge clk);
  endtask

  task automatic test_stop();
    bit ok, bad;
    int c, e0;
    do_reset();
    adc_val[0] = 10'h1C3;
    single = 1'b1;
    chn_mask = 8'h01;
    rd_chn = 3'd0;
    run = 1'b1;
    c = 0;
    while (!(ncs === 1'b0 && rise_cnt >= 10) && c < 1500) begin @(negedge clk); c++; end
    checks++;
    if (c >= 1500) $display("FAIL stop_reach_rise9: got timeout want rise 9");
    else passed++;
    run = 1'b0;
    wait_eoc_pulse(1000, ok);
    @(negedge clk);
    checks++;
    if (!ok || rd_data !== 10'h1C3)
      $display("FAIL stop_result: got ok=%b data=%h want 1/1c3", ok, rd_data);
    else passed++;
    e0 = eoc_cnt;
    bad = 1'b0;
    repeat (600) begin @(negedge clk); if (ncs !== 1'b1 || busy !== 1'b0) bad = 1'b1; end
    checks++;
    if (bad || eoc_cnt !== e0) $display("FAIL stop_idle: got bad=%b eocs=%0d want 0/0", bad, eoc_cnt - e0);
    else passed++;
    chn_mask = 8'h00;
    run = 1'b1;
    repeat (600) begin @(negedge clk); if (ncs !== 1'b1) bad = 1'b1; end
    checks++;
    if (bad || eoc_cnt !== e0) $display("FAIL mask0_idle: got bad=%b eocs=%0d want 0/0", bad, eoc_cnt - e0);
    else passed++;
    run = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int c;
    do_reset();
    adc_val[1] = 10'h111;
    adc_val[2] = 10'h222;
    single = 1'b1;
    chn_mask = 8'h06;
    rd_chn = 3'd1;
    run = 1'b1;
    wait_eoc_pulse(1500, ok);
    checks++;
    if (!ok || eoc_chn !== 3'd1) $display("FAIL rmid_first: got ok=%b chn=%0d want 1/1", ok, eoc_chn);
    else passed++;
    c = 0;
    while (!(ncs === 1'b0 && rise_cnt >= 13) && c < 1500) begin @(negedge clk); c++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ncs, busy} !== 2'b10) $display("FAIL rmid_ncs: got %b want 10", {ncs, busy});
    else passed++;
    checks++;
    if ({valid, rd_data} !== 18'd0) $display("FAIL rmid_clear: got %h want 0", {valid, rd_data});
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_eoc_pulse(1500, ok);
    run = 1'b0;
    checks++;
    if (!ok || eoc_chn !== 3'd1) $display("FAIL rmid_restart: got ok=%b chn=%0d want 1/1", ok, eoc_chn);
    else passed++;
    @(negedge clk);
    checks++;
    if (rd_data !== 10'h111) $display("FAIL rmid_data: got %h want 111", rd_data);
    else passed++;
    repeat (60) @(negedge clk);
  endtask

  task automatic test_avg();
    logic [9:0] samp [4];
    int e0, c, exp_eocs;
    logic [9:0] exp_data;
    bit tmo;
    samp = '{10'd100, 10'd101, 10'd102, 10'd105};
`ifdef MCP300X_SCAN_AVG_EN
    exp_eocs = 1;
    exp_data = 10'd102;
`else
    exp_eocs = 4;
    exp_data = 10'd105;
`endif
    do_reset();
    single = 1'b1;
    chn_mask = 8'h08;
    rd_chn = 3'd3;
    e0 = eoc_cnt;
    adc_val[3] = samp[0];
    run = 1'b1;
    tmo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c = 0;
      while (ncs !== 1'b0 && c < 1000) begin @(negedge clk); c++; end
      while (ncs !== 1'b1 && c < 2000) begin @(negedge clk); c++; end
      if (c >= 2000) tmo = 1'b1;
      if (i < 3) adc_val[3] = samp[i + 1];
      else run = 1'b0;
    end
    checks++;
    if (tmo) $display("FAIL avg_frames: got timeout want 4 frames");
    else passed++;
    repeat (60) @(negedge clk);
    checks++;
    if (eoc_cnt - e0 !== exp_eocs) $display("FAIL avg_eocs: got %0d want %0d", eoc_cnt - e0, exp_eocs);
    else passed++;
    checks++;
    if (rd_data !== exp_data) $display("FAIL avg_data: got %0d want %0d", rd_data, exp_data);
    else passed++;
    checks++;
    if (valid !== 8'h08 || eoc_log[(eoc_cnt - 1) % 64] !== 3'd3)
      $display("FAIL avg_valid: got %h/%0d want 08/3", valid, eoc_log[(eoc_cnt - 1) % 64]);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) adc_val[i] = 10'h000;
    test_reset();
    test_single_chn();
    test_timing();
    test_multi();
    test_stop();
    test_reset_mid();
    test_avg();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
